// File: rtl/coin_start_pkg.sv
// Shared types for the coin/start sequencer: FSM states, frame counter type
// and the request encoding used for both the pending slot and the start target.
package coin_start_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COIN_HI,
        ST_COIN_GAP,
        ST_START_HI,
        ST_START_GAP
    } state_t;

    typedef logic [3:0] frame_cnt_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_START1,
        PEND_START2
    } pend_t;

    // Start2 wins over a simultaneous start1.
    function automatic pend_t pick_start(input logic start1, input logic start2);
        if (start2) begin
            return PEND_START2;
        end else if (start1) begin
            return PEND_START1;
        end
        return PEND_NONE;
    endfunction

endpackage

// File: rtl/coin_start_seq_frame_tick_gen.sv
// Vblank rising-edge detector: frame_tick is a one-cycle pulse one clk_sys
// cycle after each vblank rising edge.
module frame_tick_gen (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic vblank,
    output logic frame_tick
);

    logic vblank_reg;
    logic tick_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_reg <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            vblank_reg <= vblank;
            tick_reg   <= vblank & ~vblank_reg;
        end
    end

    assign frame_tick = tick_reg;

endmodule

// File: rtl/coin_start_seq.sv
// Coin/start pulse sequencer: turns start/coin button edges into frame-timed
// coin and start pulses. Define COIN_START_SEQ_AUTOCOIN_EN to insert coins before each start.
module coin_start_seq
    import coin_start_pkg::*;
#(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic vblank,
    input  logic req_start1,
    input  logic req_start2,
    input  logic coin_in,
    output logic coin_out,
    output logic start1_out,
    output logic start2_out,
    output logic busy
);

    localparam frame_cnt_t COIN_LOAD  = frame_cnt_t'(COIN_FRAMES);
    localparam frame_cnt_t GAP_LOAD   = frame_cnt_t'(GAP_FRAMES);
    localparam frame_cnt_t START_LOAD = frame_cnt_t'(START_FRAMES);

    logic frame_tick;

    frame_tick_gen u_frame_tick_gen (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    // Bit order: [0] start1, [1] start2, [2] coin.
    logic [2:0] req_vec;
    logic [2:0] edge_vec;
    logic       armed_reg;

    assign req_vec = {coin_in, req_start2, req_start1};

    // armed_reg masks the first sample after reset so a level already high never counts.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        logic prev_reg;
        logic edge_reg;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                prev_reg <= 1'b0;
                edge_reg <= 1'b0;
            end else begin
                prev_reg <= req_vec[gi];
                edge_reg <= req_vec[gi] & ~prev_reg & armed_reg;
            end
        end

        assign edge_vec[gi] = edge_reg;
    end

    state_t     state_reg, state_next;
    frame_cnt_t cnt_reg, cnt_next;
    logic [1:0] coins_reg, coins_next;
    pend_t      target_reg, target_next;
    pend_t      pend_reg, pend_next;
    pend_t      new_start;
    pend_t      req_sel;
    logic       last_tick;
    logic       coin_reg, start1_reg, start2_reg, busy_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        coins_next  = coins_reg;
        target_next = target_reg;
        pend_next   = pend_reg;
        new_start   = pick_start(edge_vec[0], edge_vec[1]);
        req_sel     = (pend_reg != PEND_NONE) ? pend_reg : new_start;
        last_tick   = frame_tick && (cnt_reg <= 4'd1);

        if (frame_tick && (cnt_reg != 4'd0)) begin
            cnt_next = cnt_reg - 4'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (req_sel != PEND_NONE) begin
                    target_next = req_sel;
                    pend_next   = PEND_NONE;
`ifdef COIN_START_SEQ_AUTOCOIN_EN
                    coins_next  = (req_sel == PEND_START2) ? 2'd2 : 2'd1;
                    state_next  = ST_COIN_HI;
                    cnt_next    = COIN_LOAD;
`else
                    coins_next  = 2'd0;
                    state_next  = ST_START_HI;
                    cnt_next    = START_LOAD;
`endif
                end else if (edge_vec[2]) begin
                    target_next = PEND_NONE;
                    coins_next  = 2'd1;
                    state_next  = ST_COIN_HI;
                    cnt_next    = COIN_LOAD;
                end
            end
            ST_COIN_HI: begin
                if (last_tick) begin
                    state_next = ST_COIN_GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_COIN_GAP: begin
                if (last_tick) begin
                    coins_next = coins_reg - 2'd1;
                    if (coins_reg > 2'd1) begin
                        state_next = ST_COIN_HI;
                        cnt_next   = COIN_LOAD;
                    end else if (target_reg == PEND_NONE) begin
                        state_next = ST_IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = ST_START_HI;
                        cnt_next   = START_LOAD;
                    end
                end
            end
            ST_START_HI: begin
                if (last_tick) begin
                    state_next = ST_START_GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_START_GAP: begin
                if (last_tick) begin
                    state_next  = ST_IDLE;
                    cnt_next    = 4'd0;
                    target_next = PEND_NONE;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                cnt_next    = 4'd0;
                coins_next  = 2'd0;
                target_next = PEND_NONE;
            end
        endcase

        // One slot only; coin edges while busy are simply ignored.
        if ((state_reg != ST_IDLE) && (pend_reg == PEND_NONE)) begin
            pend_next = new_start;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            coins_reg  <= 2'd0;
            target_reg <= PEND_NONE;
            pend_reg   <= PEND_NONE;
            coin_reg   <= 1'b0;
            start1_reg <= 1'b0;
            start2_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            coins_reg  <= coins_next;
            target_reg <= target_next;
            pend_reg   <= pend_next;
            coin_reg   <= (state_next == ST_COIN_HI);
            start1_reg <= (state_next == ST_START_HI) && (target_next == PEND_START1);
            start2_reg <= (state_next == ST_START_HI) && (target_next == PEND_START2);
            busy_reg   <= (state_next != ST_IDLE);
        end
    end

    assign coin_out   = coin_reg;
    assign start1_out = start1_reg;
    assign start2_out = start2_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_coin_start_seq.sv
// Frame-level bench for coin_start_seq: table vectors, hand-written corner
// sequences and random requests against a per-frame schedule model.
module tb_coin_start_seq;

    localparam int C_F  = 4;
    localparam int G_F  = 8;
    localparam int S_F  = 4;
    localparam int FRAME_CYC = 16;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic vblank = 1'b0;
    logic req_start1 = 1'b0;
    logic req_start2 = 1'b0;
    logic coin_in = 1'b0;
    logic coin_out, start1_out, start2_out, busy;

    always #5 clk_sys = ~clk_sys;

    coin_start_seq #(
        .COIN_FRAMES  (C_F),
        .GAP_FRAMES   (G_F),
        .START_FRAMES (S_F)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .vblank     (vblank),
        .req_start1 (req_start1),
        .req_start2 (req_start2),
        .coin_in    (coin_in),
        .coin_out   (coin_out),
        .start1_out (start1_out),
        .start2_out (start2_out),
        .busy       (busy)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [2:0] held = 3'b000;   // [0] start1, [1] start2, [2] coin

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // One frame: vblank high for 4 cycles, request pulse at cycle 4..5, sample at cycle 12.
    task automatic do_frame(input logic [2:0] pulse, output logic [3:0] obs);
        obs = 4'b0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            vblank = (c < 4);
            if (c == 4) {coin_in, req_start2, req_start1} = pulse | held;
            if (c == 6) {coin_in, req_start2, req_start1} = held;
            if (c == 12) obs = {busy, coin_out, start1_out, start2_out};
            step();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    // ---------------- reference model: whole sequences per request ----------------
    // r: 1 = start1, 2 = start2, 3 = coin
    function automatic int n_coins(input int r);
`ifdef COIN_START_SEQ_AUTOCOIN_EN
        return (r == 2) ? 2 : 1;
`else
        return (r == 3) ? 1 : 0;
`endif
    endfunction

    function automatic int seq_len(input int r);
        return n_coins(r) * (C_F + G_F) + ((r == 3) ? 0 : (S_F + G_F));
    endfunction

    function automatic logic [3:0] seq_code(input int r, input int idx);
        int ci;
        logic cn, s1, s2;
        ci = n_coins(r) * (C_F + G_F);
        cn = 1'b0; s1 = 1'b0; s2 = 1'b0;
        if (idx < ci) begin
            cn = ((idx % (C_F + G_F)) < C_F);
        end else if ((idx - ci) < S_F) begin
            s1 = (r == 1);
            s2 = (r == 2);
        end
        return {1'b1, cn, s1, s2};
    endfunction

    int st_q[$];
    int ty_q[$];

    function automatic logic [3:0] model_at(input int f);
        for (int i = 0; i < st_q.size(); i++) begin
            if (f >= st_q[i] && f < st_q[i] + seq_len(ty_q[i])) return seq_code(ty_q[i], f - st_q[i]);
        end
        return 4'b0;
    endfunction

    task automatic model_request(input int f, input int r);
        logic running, pending;
        int last_end;
        running = 1'b0; pending = 1'b0; last_end = 0;
        for (int i = 0; i < st_q.size(); i++) begin
            if (f >= st_q[i] && f < st_q[i] + seq_len(ty_q[i])) running = 1'b1;
            if (st_q[i] > f) pending = 1'b1;
            if (st_q[i] + seq_len(ty_q[i]) > last_end) last_end = st_q[i] + seq_len(ty_q[i]);
        end
        if (r == 0) return;
        if (!running && !pending) begin
            st_q.push_back(f); ty_q.push_back(r);
            $display("frame %0d: request %0d starts now", f, r);
        end else if (running && !pending && r != 3) begin
            st_q.push_back(last_end); ty_q.push_back(r);
            $display("frame %0d: request %0d pending until frame %0d", f, r, last_end);
        end else begin
            $display("frame %0d: request %0d dropped", f, r);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [2:0] mask;
        int coin_p;
        int coin_f;
        int s1_p;
        int s2_p;
        int start_f;
        int busy_f;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [3:0] obs, prev, expv;
        int coin_p, coin_f, s1_p, s2_p, start_f, busy_f, busy_rise, wait_f;
        logic seen;
        logic [2:0] m;
        int r;

`ifdef COIN_START_SEQ_AUTOCOIN_EN
        vecs[0] = '{3'b001, 1, 4, 1, 0, 4, 24};
        vecs[1] = '{3'b010, 2, 8, 0, 1, 4, 36};
        vecs[2] = '{3'b011, 2, 8, 0, 1, 4, 36};
        vecs[3] = '{3'b100, 1, 4, 0, 0, 0, 12};
`else
        vecs[0] = '{3'b001, 0, 0, 1, 0, 4, 12};
        vecs[1] = '{3'b010, 0, 0, 0, 1, 4, 12};
        vecs[2] = '{3'b011, 0, 0, 0, 1, 4, 12};
        vecs[3] = '{3'b100, 1, 4, 0, 0, 0, 12};
`endif

        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        check("reset_outputs", int'({busy, coin_out, start1_out, start2_out}), 0);
        reset_n = 1'b1;
        step();

        foreach (vecs[v]) begin
            do_frame(3'b000, obs);
            do_frame(3'b000, obs);
            coin_p = 0; coin_f = 0; s1_p = 0; s2_p = 0; start_f = 0; busy_f = 0;
            prev = 4'b0;
            for (int f = 0; f < 60; f++) begin
                do_frame((f == 0) ? vecs[v].mask : 3'b000, obs);
                if (obs[2] && !prev[2]) coin_p++;
                if (obs[1] && !prev[1]) s1_p++;
                if (obs[0] && !prev[0]) s2_p++;
                if (obs[2]) coin_f++;
                if (obs[1] | obs[0]) start_f++;
                if (obs[3]) busy_f++;
                prev = obs;
            end
            $display("vector %0d mask=%b: coin_p=%0d s1_p=%0d s2_p=%0d busy_f=%0d", v, vecs[v].mask, coin_p, s1_p, s2_p, busy_f);
            check("vec_coin_pulses", coin_p, vecs[v].coin_p);
            check("vec_coin_frames", coin_f, vecs[v].coin_f);
            check("vec_start1_pulses", s1_p, vecs[v].s1_p);
            check("vec_start2_pulses", s2_p, vecs[v].s2_p);
            check("vec_start_frames", start_f, vecs[v].start_f);
            check("vec_busy_frames", busy_f, vecs[v].busy_f);
        end

        // start1 held for 100 frames: one sequence only
        held = 3'b001;
        busy_rise = 0; s1_p = 0; prev = 4'b0;
        for (int f = 0; f < 100; f++) begin
            do_frame(3'b000, obs);
            if (obs[3] && !prev[3]) busy_rise++;
            if (obs[1] && !prev[1]) s1_p++;
            prev = obs;
        end
        held = 3'b000;
        $display("held start1: sequences=%0d start1 pulses=%0d", busy_rise, s1_p);
        check("held_sequences", busy_rise, 1);
        check("held_start1_pulses", s1_p, 1);

        // second edge mid-sequence runs again straight after IDLE
        do_frame(3'b000, obs);
        busy_rise = 0; busy_f = 0; s1_p = 0; prev = 4'b0;
        for (int f = 0; f < 60; f++) begin
            do_frame((f == 0 || f == 5) ? 3'b001 : 3'b000, obs);
            if (obs[3] && !prev[3]) busy_rise++;
            if (obs[3]) busy_f++;
            if (obs[1] && !prev[1]) s1_p++;
            prev = obs;
        end
        $display("back-to-back start1: busy runs=%0d busy frames=%0d start1 pulses=%0d", busy_rise, busy_f, s1_p);
        check("b2b_busy_runs", busy_rise, 1);
        check("b2b_busy_frames", busy_f, 2 * seq_len(1));
        check("b2b_start1_pulses", s1_p, 2);

        // reset during START_HI
        seen = 1'b0;
        wait_f = 0;
        do_frame(3'b001, obs);
        while (!obs[1] && wait_f < 40) begin
            do_frame(3'b000, obs);
            wait_f++;
        end
        check("reset_reach_start_hi", int'(start1_out), 1);
        #2 reset_n = 1'b0;
        #1 check("reset_async_clear", int'({busy, coin_out, start1_out, start2_out}), 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        busy_f = 0;
        for (int f = 0; f < 40; f++) begin
            do_frame(3'b000, obs);
            if (obs != 4'b0) busy_f++;
        end
        $display("after mid-sequence reset: active frames=%0d", busy_f);
        check("reset_no_resume", busy_f, 0);

        // levels already high at reset release give no request
        held = 3'b111;
        {coin_in, req_start2, req_start1} = held;
        do_reset();
        busy_f = 0;
        for (int f = 0; f < 30; f++) begin
            do_frame(3'b000, obs);
            if (obs[3]) busy_f++;
        end
        held = 3'b000;
        do_frame(3'b000, obs);
        $display("high levels at reset release: busy frames=%0d", busy_f);
        check("release_high_no_request", busy_f, 0);

        // random requests against the schedule model
        do_reset();
        for (int f = 0; f < 400; f++) begin
            m = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            r = m[1] ? 2 : (m[0] ? 1 : (m[2] ? 3 : 0));
            model_request(f, r);
            do_frame(m, obs);
            expv = model_at(f);
            check("rand_frame", int'(obs), int'(expv));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
